// File: rtl/conv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : conv_pkg
// Description : Shared types and helpers for the bit-serial two's-complement
//               to sign/magnitude converter.
//               - state_t    : FSM state encoding (IDLE, SHIFT, DONE)
//               - cnt_width  : bit-counter width, $clog2(WIDTH)
//               - most_neg   : most-negative two's-complement pattern
// Revision    : 1.0 - initial release
// ============================================================================
package conv_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   // Counter must reach WIDTH-1; a floor of 1 keeps the vector legal.
   function automatic int cnt_width(input int w);
      return (w > 1) ? $clog2(w) : 1;
   endfunction

   // 1 followed by w-1 zeros, right-aligned in a 64-bit container.
   function automatic logic [63:0] most_neg(input int w);
      return 64'd1 << (w - 1);
   endfunction

endpackage
`default_nettype wire

// File: rtl/complemento2_bit.sv
`default_nettype none
// ============================================================================
// Module      : complemento2_bit
// Description : One bit slice of the conditional two's-complement rule.
//               With select=1 the bit is inverted and the running carry is
//               added (ripple started at 1 by the caller); with select=0 the
//               bit and carry pass through unchanged.
// Ports       : A      in  operand bit
//               Cin    in  incoming carry
//               select in  1 = complement, 0 = pass through
//               R      out result bit
//               Cout   out outgoing carry
// Revision    : 1.0 - initial release
// ============================================================================
module complemento2_bit (
   input  logic A,
   input  logic Cin,
   input  logic select,
   output logic R,
   output logic Cout
);

   always_comb begin
      R    = A;
      Cout = Cin;
      if (select) begin
         R    = ~A ^ Cin;
         Cout = ~A & Cin;
      end
   end

endmodule
`default_nettype wire

// File: rtl/conversor_sinal_magnitude.sv
`default_nettype none
// ============================================================================
// Module      : conversor_sinal_magnitude
// Description : Bit-serial two's-complement to sign/magnitude decoder.
//               Accepts one operand on a valid/ready handshake, converts one
//               bit per clock LSB first, then presents the registered result
//               on a second valid/ready handshake.
// Ports       : clk         in   clock, rising edge
//               rst         in   asynchronous active-high reset
//               in_valid    in   in_data is valid
//               in_ready    out  block can accept an operand (state IDLE)
//               in_data     in   two's-complement operand [WIDTH-1:0]
//               out_valid   out  result is valid (state DONE)
//               out_ready   in   consumer accepts the result
//               out_sign    out  operand was negative
//               out_mag     out  |in_data| [WIDTH-1:0]
//               out_min_neg out  operand was the most-negative value
//                                (only when CONV_MINNEG_EN is defined)
// Build macro : CONV_MINNEG_EN - adds the out_min_neg flag and its register.
// Revision    : 1.0 - initial release
// ============================================================================
module conversor_sinal_magnitude
   import conv_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             out_sign,
   output logic [WIDTH-1:0] out_mag
`ifdef CONV_MINNEG_EN
   ,
   output logic             out_min_neg
`endif
);

   localparam int             CW       = cnt_width(WIDTH);
   localparam logic [CW-1:0]  LAST_CNT = CW'(WIDTH - 1);

   // ------------------------------------------------------------------------
   // State and datapath registers
   // ------------------------------------------------------------------------
   state_t             state_q;
   state_t             state_d;
   logic [WIDTH-1:0]   sreg_q;
   logic [WIDTH-2:0]   res_q;
   logic               sign_q;
   logic               carry_q;
   logic [CW-1:0]      cnt_q;
   logic               out_sign_q;
   logic [WIDTH-1:0]   out_mag_q;

   logic               accept;
   logic               last_bit;
   logic               bit_r;
   logic               bit_cout;
   logic [WIDTH-1:0]   res_next;

   assign accept   = in_valid && (state_q == IDLE);
   assign last_bit = (state_q == SHIFT) && (cnt_q == LAST_CNT);

   // Serial result: each new bit enters at the MSB, so after WIDTH shifts
   // the first (LSB) bit has arrived at position 0.
   assign res_next = {bit_r, res_q};

   complemento2_bit u_bit (
      .A      (sreg_q[0]),
      .Cin    (carry_q),
      .select (sign_q),
      .R      (bit_r),
      .Cout   (bit_cout)
   );

   // ------------------------------------------------------------------------
   // FSM: state register
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // ------------------------------------------------------------------------
   // FSM: next-state logic
   // ------------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            if (cnt_q == LAST_CNT) begin
               state_d = DONE;
            end
         end
         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // ------------------------------------------------------------------------
   // FSM: outputs (pure state decode, no path from in_valid)
   // ------------------------------------------------------------------------
   always_comb begin
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (state_q)
         IDLE:    in_ready  = 1'b1;
         DONE:    out_valid = 1'b1;
         default: ;
      endcase
   end

   // ------------------------------------------------------------------------
   // Serial datapath
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sreg_q     <= '0;
         res_q      <= '0;
         sign_q     <= 1'b0;
         carry_q    <= 1'b0;
         cnt_q      <= '0;
         out_sign_q <= 1'b0;
         out_mag_q  <= '0;
      end else if (accept) begin
         sreg_q  <= in_data;
         sign_q  <= in_data[WIDTH-1];
         carry_q <= 1'b1;
         cnt_q   <= '0;
      end else if (state_q == SHIFT) begin
         sreg_q  <= sreg_q >> 1;
         res_q   <= res_next[WIDTH-1:1];
         carry_q <= bit_cout;
         cnt_q   <= cnt_q + CW'(1);
         // Output registers load only once the full word is ready, so
         // they never change while out_valid is high.
         if (last_bit) begin
            out_mag_q  <= res_next;
            out_sign_q <= sign_q;
         end
      end
   end

   assign out_sign = out_sign_q;
   assign out_mag  = out_mag_q;

`ifdef CONV_MINNEG_EN
   localparam logic [WIDTH-1:0] MOST_NEG = WIDTH'(most_neg(WIDTH));

   logic min_neg_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         min_neg_q <= 1'b0;
      end else if (accept) begin
         min_neg_q <= (in_data == MOST_NEG);
      end
   end

   assign out_min_neg = min_neg_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_conversor_sinal_magnitude.sv
`default_nettype none
// ============================================================================
// Module      : tb_conversor_sinal_magnitude
// Description : Scoreboard bench for conversor_sinal_magnitude (WIDTH=4).
//               The driver pushes the expected result of every accepted
//               operand; a monitor pops and compares on each output
//               handshake, and also checks latency and output hold.
// Build macro : CONV_MINNEG_EN - also checks out_min_neg.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_conversor_sinal_magnitude;

   localparam int WIDTH = 4;

   typedef struct {
      logic             s;
      logic [WIDTH-1:0] m;
      logic             mn;
   } exp_t;

   logic             clk;
   logic             rst;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_data;
   logic             out_valid;
   logic             out_ready;
   logic             out_sign;
   logic [WIDTH-1:0] out_mag;
   logic             out_min_neg;

   int   tests;
   int   fails;
   int   cyc;
   int   acc_cyc;
   bit   rand_mode;
   exp_t sb_q[$];

   conversor_sinal_magnitude #(.WIDTH(WIDTH)) dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_data    (in_data),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_sign   (out_sign),
      .out_mag    (out_mag)
`ifdef CONV_MINNEG_EN
      ,
      .out_min_neg(out_min_neg)
`endif
   );

`ifndef CONV_MINNEG_EN
   assign out_min_neg = 1'b0;
`endif

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // ------------------------------------------------------------------------
   // Monitor: acceptance time, latency, hold, and scoreboard compare
   // ------------------------------------------------------------------------
   logic             prev_v;
   logic             held_v;
   logic             held_s;
   logic [WIDTH-1:0] held_m;

   initial begin
      prev_v = 1'b0;
      held_v = 1'b0;
   end

   always @(negedge clk) begin
      exp_t e;
      if (rst) begin
         prev_v = 1'b0;
         held_v = 1'b0;
      end else begin
         if (in_valid && in_ready) acc_cyc = cyc + 1;
         if (out_valid && !prev_v) chk("latency", 32'(cyc - acc_cyc), WIDTH);
         if (held_v) begin
            chk("hold_valid", {31'b0, out_valid}, 1);
            chk("hold_sign", {31'b0, out_sign}, {31'b0, held_s});
            chk("hold_mag", {28'b0, out_mag}, {28'b0, held_m});
         end
         if (out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL unexpected_result: got %b/%b expected none", out_sign, out_mag);
            end else begin
               e = sb_q.pop_front();
               chk("out_sign", {31'b0, out_sign}, {31'b0, e.s});
               chk("out_mag", {28'b0, out_mag}, {28'b0, e.m});
`ifdef CONV_MINNEG_EN
               chk("out_min_neg", {31'b0, out_min_neg}, {31'b0, e.mn});
`endif
            end
         end
         held_v = out_valid && !out_ready;
         held_s = out_sign;
         held_m = out_mag;
         prev_v = out_valid;
      end
   end

   // Random consumer stalls when enabled
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (rand_mode) out_ready = 1'($urandom_range(0, 1));
      end
   end

   // ------------------------------------------------------------------------
   // Driver
   // ------------------------------------------------------------------------
   task automatic send(input logic [WIDTH-1:0] d, input logic s, input logic [WIDTH-1:0] m,
                       input logic mn, input bit push);
      int t;
      exp_t e;
      t = 0;
      in_valid = 1'b1;
      in_data  = d;
      while (!in_ready && t < 100) begin
         @(posedge clk);
         #1;
         t++;
      end
      if (!in_ready) begin
         tests++;
         fails++;
         $display("FAIL accept_timeout: got in_ready=0 expected 1");
         in_valid = 1'b0;
         return;
      end
      if (push) begin
         e.s  = s;
         e.m  = m;
         e.mn = mn;
         sb_q.push_back(e);
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic drain();
      int t;
      t = 0;
      while ((sb_q.size() != 0 || out_valid) && t < 400) begin
         @(posedge clk);
         #1;
         t++;
      end
      chk("drain_empty", 32'(sb_q.size()), 0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   // ------------------------------------------------------------------------
   // Stimulus
   // ------------------------------------------------------------------------
   initial begin
      logic [WIDTH-1:0] x;
      logic [WIDTH-1:0] mm;
      int t;
      bit seen;
      tests     = 0;
      fails     = 0;
      cyc       = 0;
      acc_cyc   = 0;
      rand_mode = 1'b0;
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_data   = '0;
      out_ready = 1'b0;

      #2;
      chk("rst_in_ready", {31'b0, in_ready}, 1);
      chk("rst_out_valid", {31'b0, out_valid}, 0);
      chk("rst_out_sign", {31'b0, out_sign}, 0);
      chk("rst_out_mag", {28'b0, out_mag}, 0);
      chk("rst_min_neg", {31'b0, out_min_neg}, 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      out_ready = 1'b1;

      // Directed vectors, hand-computed results
      send(4'b1101, 1'b1, 4'b0011, 1'b0, 1'b1);
      send(4'b0101, 1'b0, 4'b0101, 1'b0, 1'b1);
      send(4'b0000, 1'b0, 4'b0000, 1'b0, 1'b1);
      send(4'b1000, 1'b1, 4'b1000, 1'b1, 1'b1);
      send(4'b1111, 1'b1, 4'b0001, 1'b0, 1'b1);
      send(4'b0111, 1'b0, 4'b0111, 1'b0, 1'b1);
      send(4'b0001, 1'b0, 4'b0001, 1'b0, 1'b1);
      drain();

      // Back-pressure: result must hold and 0111 must never be accepted
      out_ready = 1'b0;
      send(4'b1101, 1'b1, 4'b0011, 1'b0, 1'b1);
      t = 0;
      while (!out_valid && t < 20) begin
         @(posedge clk);
         #1;
         t++;
      end
      chk("bp_out_valid", {31'b0, out_valid}, 1);
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1;
         in_data  = 4'b0111;
         @(posedge clk);
         #1;
         chk("bp_in_ready", {31'b0, in_ready}, 0);
         chk("bp_valid", {31'b0, out_valid}, 1);
         chk("bp_sign", {31'b0, out_sign}, 1);
         chk("bp_mag", {28'b0, out_mag}, 4'b0011);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      seen = 1'b0;
      for (int i = 0; i < WIDTH + 4; i++) begin
         @(posedge clk);
         #1;
         if (out_valid) seen = 1'b1;
      end
      chk("bp_no_accept", {31'b0, seen}, 0);

      // Reset two cycles into SHIFT aborts the conversion
      send(4'b0101, 1'b0, 4'b0101, 1'b0, 1'b0);
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      chk("abort_out_valid", {31'b0, out_valid}, 0);
      chk("abort_in_ready", {31'b0, in_ready}, 1);
      @(posedge clk);
      #1;
      rst = 1'b0;
      chk("post_rst_in_ready", {31'b0, in_ready}, 1);
      seen = 1'b0;
      for (int i = 0; i < WIDTH + 2; i++) begin
         @(posedge clk);
         #1;
         if (out_valid) seen = 1'b1;
      end
      chk("abort_no_pulse", {31'b0, seen}, 0);
      send(4'b1110, 1'b1, 4'b0010, 1'b0, 1'b1);
      drain();

      // Exhaustive sweep with random consumer stalls
      rand_mode = 1'b1;
      for (int v = 0; v < 16; v++) begin
         x  = 4'(v);
         mm = x[WIDTH-1] ? 4'(-v + 16) : x;
         send(x, x[WIDTH-1], mm, (x == 4'b1000), 1'b1);
      end
      drain();
      rand_mode = 1'b0;
      out_ready = 1'b1;

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
`default_nettype wire
